// File: rtl/fibonacci_checker.sv
// fibonacci_checker: consumer-side checker for a Fibonacci-style sample stream.
// Seeds itself from any two accepted samples, predicts each next sample as the
// modulo-2^WIDTH sum of the previous two, locks after LOCK_COUNT consecutive
// correct predictions and flags mismatches seen while locked.
module fibonacci_checker #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 locked,
  output logic                 error,
  output logic [WIDTH-1:0]     expected,
  output logic [CNT_WIDTH-1:0] match_count,
  output logic [CNT_WIDTH-1:0] error_count
);

  typedef enum logic [1:0] {HUNT, PRIME, TRACK, LOCKED} state_t;

  localparam logic [7:0]           LOCK_N  = 8'(LOCK_COUNT);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t           state;
  logic [WIDTH-1:0] p, c;
  logic [7:0]       streak;

  logic [WIDTH-1:0] p_nxt, c_nxt, sum_nxt;
  logic             hit;

  // Next sample-history values: HUNT only captures c; every other state shifts
  // the window. A reseed after a mismatch is the same shift (c, in_data), so
  // one path covers matches and reseeds alike.
  always_comb begin
    p_nxt = p;
    c_nxt = c;
    if (in_valid) begin
      if (state == HUNT) begin
        c_nxt = in_data;
      end else begin
        p_nxt = c;
        c_nxt = in_data;
      end
    end
    sum_nxt = p_nxt + c_nxt;   // carry drops out: wrap-around is legal
    hit     = (in_data == expected);
  end

  // Checker FSM with registered outputs and saturating counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= HUNT;
      p           <= '0;
      c           <= '0;
      streak      <= '0;
      locked      <= 1'b0;
      error       <= 1'b0;
      expected    <= '0;
      match_count <= '0;
      error_count <= '0;
    end else begin
      error <= 1'b0;
      if (in_valid) begin
        p <= p_nxt;
        c <= c_nxt;
        case (state)
          HUNT: begin
            state <= PRIME;
          end
          PRIME: begin
            streak   <= '0;
            expected <= sum_nxt;
            state    <= TRACK;
          end
          TRACK: begin
            expected <= sum_nxt;
            if (hit) begin
              if (match_count != CNT_MAX) match_count <= match_count + 1'b1;
              streak <= streak + 8'd1;
              if (streak + 8'd1 == LOCK_N) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              // pre-lock glitch: quietly reseed and restart the streak
              streak <= '0;
            end
          end
          LOCKED: begin
            expected <= sum_nxt;
            if (hit) begin
              if (match_count != CNT_MAX) match_count <= match_count + 1'b1;
            end else begin
              error  <= 1'b1;
              if (error_count != CNT_MAX) error_count <= error_count + 1'b1;
              streak <= '0;
              locked <= 1'b0;
              state  <= TRACK;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
